// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
// Shared definitions for the multiplexed seven-segment driver:
//   - scan_state_e : GUARD / DRIVE phase of a digit slot
//   - hex_to_seg   : hex nibble to segment pattern (gfedcba, active-high)
//   - slot_len     : cycles per digit slot (guard + 15 brightness steps)
//   - reg_width    : counter/index width for a given range (minimum 1 bit)
package seven_segment_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int WR_DATA_W  = 9;
  localparam int MAX_BRIGHT = 15;

  // Hex-to-segment table, bit order gfedcba, 1 = lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  function automatic int slot_len(input int dead_cycles, input int step);
    return dead_cycles + MAX_BRIGHT * step;
  endfunction

  function automatic int reg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
// Combinational decode of one 9-bit digit register.
//   data_i[8] = 1 : raw mode, seg_o = data_i[6:0], dp_o = data_i[7]
//   data_i[8] = 0 : hex mode, seg_o = table(data_i[3:0]), dp_o = data_i[4]
// Ports: data_i (9) in, seg_o (7, gfedcba, active-high) out, dp_o (1) out.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [WR_DATA_W-1:0] data_i,
  output logic [6:0]           seg_o,
  output logic                 dp_o
);

  // Raw/hex decode of the register contents.
  always_comb begin
    seg_o = 7'h00;
    dp_o  = 1'b0;
    if (data_i[8]) begin
      seg_o = data_i[6:0];
      dp_o  = data_i[7];
    end else begin
      seg_o = hex_to_seg(data_i[3:0]);
      dp_o  = data_i[4];
    end
  end

endmodule

// File: rtl/seven_segment_mux.sv
// seven_segment_mux
// Time-multiplexed seven-segment driver with per-slot guard time and PWM
// brightness. Each digit owns a slot of DEAD_CYCLES + 15*STEP cycles; the
// digit is lit from p = DEAD_CYCLES until p < DEAD_CYCLES + b*STEP.
// Ports:
//   io_mainClk, io_asyncReset     clock, async active-high reset
//   io_wr_valid/addr/data         digit register write port
//   io_brightness                 on-time in steps (0..15)
//   io_digitPins, io_segPins,     registered display pins
//   io_dpPin, io_frameTick        (frameTick marks end of last digit's slot)
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int STEP             = 750,
  parameter int DEAD_CYCLES      = 64,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                         io_mainClk,
  input  logic                         io_asyncReset,
  input  logic                         io_wr_valid,
  input  logic [reg_width(DIGITS)-1:0] io_wr_addr,
  input  logic [WR_DATA_W-1:0]         io_wr_data,
  input  logic [3:0]                   io_brightness,
  output logic [DIGITS-1:0]            io_digitPins,
  output logic [6:0]                   io_segPins,
  output logic                         io_dpPin,
  output logic                         io_frameTick
);

  localparam int SLOT  = slot_len(DEAD_CYCLES, STEP);
  localparam int CNT_W = reg_width(SLOT);
  localparam int AW    = reg_width(DIGITS);

  localparam logic [31:0]      DEAD_U    = 32'(DEAD_CYCLES);
  localparam logic [31:0]      STEP_U    = 32'(STEP);
  localparam logic [31:0]      DIGITS_U  = 32'(DIGITS);
  localparam logic [CNT_W-1:0] P_LAST    = CNT_W'(SLOT - 1);
  localparam logic [AW-1:0]    SCAN_LAST = AW'(DIGITS - 1);
  localparam scan_state_e      ST_RESET  = (DEAD_CYCLES > 0) ? ST_GUARD : ST_DRIVE;

  logic [CNT_W-1:0]     p_q, p_d;
  logic [AW-1:0]        scan_q, scan_d;
  scan_state_e          state_q, state_d;
  logic [WR_DATA_W-1:0] digit_q [DIGITS];
  logic [WR_DATA_W-1:0] slot_data_q, slot_data_d;
  logic [3:0]           slot_bright_q, slot_bright_d;

  logic                 wrap_s;
  logic                 lit_s;
  logic [31:0]          lit_end_s;
  logic [6:0]           dec_seg_s;
  logic                 dec_dp_s;
  logic [DIGITS-1:0]    onehot_s;

  logic [DIGITS-1:0]    digit_pins_q, digit_pins_d;
  logic [6:0]           seg_pins_q, seg_pins_d;
  logic                 dp_pin_q, dp_pin_d;
  logic                 frame_tick_q, frame_tick_d;

  assign wrap_s = (p_q == P_LAST);

  // Phase counter, scan index and GUARD/DRIVE next state. The state is
  // derived from the next phase so state_q always matches p_q.
  always_comb begin
    p_d     = p_q + CNT_W'(1);
    scan_d  = scan_q;
    state_d = ST_DRIVE;
    if (wrap_s) begin
      p_d = '0;
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + AW'(1);
      end
    end else begin
      scan_d = scan_q;
    end
    if (32'(p_d) < DEAD_U) begin
      state_d = ST_GUARD;
    end else begin
      state_d = ST_DRIVE;
    end
  end

  // Scan state registers.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      p_q     <= '0;
      scan_q  <= '0;
      state_q <= ST_RESET;
    end else begin
      p_q     <= p_d;
      scan_q  <= scan_d;
      state_q <= state_d;
    end
  end

  // Digit register file; out-of-range addresses are dropped.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= 9'h000;
      end
    end else if (io_wr_valid && (32'(io_wr_addr) < DIGITS_U)) begin
      digit_q[io_wr_addr] <= io_wr_data;
    end
  end

  // At p==0 the slot uses the freshly sampled register/brightness so the
  // first cycle of a slot already sees the new snapshot; afterwards the
  // held copy isolates the slot from writes and brightness changes.
  always_comb begin
    slot_data_d   = slot_data_q;
    slot_bright_d = slot_bright_q;
    if (p_q == '0) begin
      slot_data_d   = digit_q[scan_q];
      slot_bright_d = io_brightness;
    end else begin
      slot_data_d   = slot_data_q;
      slot_bright_d = slot_bright_q;
    end
  end

  // Slot snapshot registers.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      slot_data_q   <= 9'h000;
      slot_bright_q <= 4'h0;
    end else begin
      slot_data_q   <= slot_data_d;
      slot_bright_q <= slot_bright_d;
    end
  end

  seven_segment_decoder u_decoder (
    .data_i (slot_data_d),
    .seg_o  (dec_seg_s),
    .dp_o   (dec_dp_s)
  );

  assign lit_end_s = DEAD_U + (32'(slot_bright_d) * STEP_U);

  // Pin values for the current counter state, polarity applied last.
  always_comb begin
    lit_s        = (state_q == ST_DRIVE) && (32'(p_q) < lit_end_s);
    onehot_s     = '0;
    seg_pins_d   = 7'h00;
    dp_pin_d     = 1'b0;
    if (lit_s) begin
      onehot_s   = DIGITS'(1'b1) << scan_q;
      seg_pins_d = dec_seg_s;
      dp_pin_d   = dec_dp_s;
    end else begin
      onehot_s   = '0;
    end
    digit_pins_d = onehot_s ^ {DIGITS{DIGIT_ACTIVE_LOW}};
    seg_pins_d   = seg_pins_d ^ {7{SEG_ACTIVE_LOW}};
    dp_pin_d     = dp_pin_d ^ SEG_ACTIVE_LOW;
    frame_tick_d = wrap_s && (scan_q == SCAN_LAST);
  end

  // Output registers; reset forces every pin inactive immediately.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      digit_pins_q <= {DIGITS{DIGIT_ACTIVE_LOW}};
      seg_pins_q   <= {7{SEG_ACTIVE_LOW}};
      dp_pin_q     <= SEG_ACTIVE_LOW;
      frame_tick_q <= 1'b0;
    end else begin
      digit_pins_q <= digit_pins_d;
      seg_pins_q   <= seg_pins_d;
      dp_pin_q     <= dp_pin_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign io_digitPins = digit_pins_q;
  assign io_segPins   = seg_pins_q;
  assign io_dpPin     = dp_pin_q;
  assign io_frameTick = frame_tick_q;

endmodule
